change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Consumer end of the vending controller's vend interface: takes the one-cycle soda pulse and 3-bit change code (units of 5 cents).
- Drives the soda-release actuator, then pays change coin by coin through request/acknowledge handshakes to a dime hopper and a nickel hopper.
- Sits between the vending FSM and the mechanical actuators; reports busy, done and fault status.

Parameters:
- CHANGE_W, 3, width of the change code in nickel units (max 2^CHANGE_W-1 nickels).
- TIMEOUT_CYC, 16, cycles an actuator request may stay unacknowledged before fault.
- TMR_W, 5, width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- i_clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_vend  in  1  one-cycle vend pulse from the vending controller.
- i_change  in  CHANGE_W  change owed in nickels; sampled only with i_vend.
- i_dime_empty  in  1  dime hopper empty; level, sampled at each coin decision.
- o_soda_req  out  1  soda release request; held until i_soda_ack.
- i_soda_ack  in  1  soda released.
- o_dime_req  out  1  eject one dime; held until i_dime_ack.
- i_dime_ack  in  1  dime ejected.
- o_nickel_req  out  1  eject one nickel; held until i_nickel_ack.
- i_nickel_ack  in  1  nickel ejected.
- o_busy  out  1  high from the cycle after an accepted i_vend until the cycle after DONE; high in FAULT.
- o_done  out  1  one-cycle pulse when a transaction completes.
- o_fault  out  1  sticky actuator timeout flag; cleared only by reset.

Behaviour:
- Reset (async, active-high): state IDLE; remaining=0; timer=0; all outputs 0.
- All outputs are registered.
- States: IDLE, SODA, COIN_REQ, COIN_GAP, DONE, FAULT.
- IDLE:
  - i_vend=1 at edge t: latch remaining=i_change; enter SODA.
  - o_soda_req=1 and o_busy=1 from t+1.
- SODA:
  - Hold o_soda_req. If i_soda_ack is high at edge k, drop o_soda_req at k+1 and enter COIN_GAP (remaining>0) or DONE (remaining=0).
- COIN_GAP: one cycle with all requests low, then coin decision into COIN_REQ:
  - dime if remaining>=2 and i_dime_empty=0;
  - otherwise nickel.
- COIN_REQ:
  - Hold the chosen request. The matching ack at edge k drops the request at k+1 and decrements remaining (by 2 for dime, 1 for nickel).
  - Next state is COIN_GAP if remaining is still >0, else DONE.
  - Acks on non-active channels are ignored.
- DONE: o_done=1 for exactly one cycle; o_busy drops the next cycle; return to IDLE.
- Timeout:
  - timer clears on entering SODA/COIN_REQ and increments each cycle the request is unacked.
  - On reaching TIMEOUT_CYC, the request drops next cycle, o_fault=1, enter FAULT.
  - An ack arriving in the same cycle as expiry wins (no fault).
- FAULT: all requests 0, o_busy=1, o_done=0; stays until reset.
- i_vend outside IDLE is ignored entirely; i_change is not sampled.
- remaining never underflows: a dime is never chosen with remaining<2.
- Reset mid-transaction drops requests immediately (async) and discards the owed change.

Optional Feature:
- Macro CHANGE_LOG_EN.
- Defined: adds output o_nickels_paid [7:0], reset 0.
  - +2 per acked dime, +1 per acked nickel.
  - Saturates at 255.
  - Not cleared by DONE.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package change_pkg holds:
  - state enum (IDLE, SODA, COIN_REQ, COIN_GAP, DONE, FAULT);
  - constants NICKEL_UNITS=1 and DIME_UNITS=2;
  - coin-select enum (COIN_NICKEL, COIN_DIME).
- One natural sub-module, hs_timer: clear/enable/expire timeout counter parameterised by TIMEOUT_CYC and TMR_W, instantiated once.

Test Plan:
- Zero change:
  - Stimulus: i_vend with i_change=0; i_soda_ack 3 cycles after o_soda_req rises.
  - Expected: no coin requests; o_done single pulse; o_busy low one cycle after o_done.
- Change 3:
  - Stimulus: i_change=3, i_dime_empty=0; each ack given 2 cycles after its request.
  - Expected: soda, then one dime, then one nickel; at least one all-low gap cycle between requests; one o_done.
- Empty dime hopper:
  - Stimulus: i_change=4, i_dime_empty=1.
  - Expected: exactly four nickel handshakes and zero dime requests.
- Timeout:
  - Stimulus: i_change=1, nickel never acked, TIMEOUT_CYC=16.
  - Expected: o_nickel_req drops after 16 cycles; o_fault=1 and o_busy=1 persist until reset.
- Busy vend and mid-transaction reset:
  - Stimulus: i_vend with i_change=4 pulsed during SODA.
  - Expected: the second vend is ignored.
  - Stimulus: assert reset during a dime request.
  - Expected: all outputs 0 immediately; next vend behaves from IDLE.
- With CHANGE_LOG_EN:
  - Stimulus: run transactions with change 3 then 4.
  - Expected: o_nickels_paid=7.

Source files
------------

// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM states, coin
// selection and coin values in nickel units.
package change_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SODA,
        COIN_REQ,
        COIN_GAP,
        DONE,
        FAULT
    } state_e;

    typedef enum logic {
        COIN_NICKEL,
        COIN_DIME
    } coin_e;

    localparam int unsigned NICKEL_UNITS = 1;
    localparam int unsigned DIME_UNITS   = 2;

endpackage

// File: rtl/hs_timer.sv
// Handshake timeout counter: cleared on entry to a request state, counts
// unacknowledged cycles and flags the cycle that would exhaust the budget.
module hs_timer #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned TMR_W       = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    // Expiry is raised while the last permitted unacked cycle is in progress,
    // so a request is held for exactly TIMEOUT_CYC cycles before faulting.
    localparam logic [TMR_W-1:0] LastCnt = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && count_q != '1) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == LastCnt);

endmodule

// File: rtl/change_dispenser.sv
// Vend-interface consumer: releases the soda, then pays change coin by coin
// over dime/nickel hopper handshakes. Define CHANGE_LOG_EN for o_nickels_paid.
module change_dispenser
    import change_pkg::*;
#(
    parameter int unsigned CHANGE_W    = 3,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned TMR_W       = 5
) (
    input  logic                i_clk,
    input  logic                reset,
    input  logic                i_vend,
    input  logic [CHANGE_W-1:0] i_change,
    input  logic                i_dime_empty,
    output logic                o_soda_req,
    input  logic                i_soda_ack,
    output logic                o_dime_req,
    input  logic                i_dime_ack,
    output logic                o_nickel_req,
    input  logic                i_nickel_ack,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_fault
`ifdef CHANGE_LOG_EN
    ,
    output logic [7:0]          o_nickels_paid
`endif
);

    state_e              state_q, state_d;
    coin_e               coin_q, coin_d;
    logic [CHANGE_W-1:0] remaining_q, remaining_d;
    logic                soda_req_q, dime_req_q, nickel_req_q, busy_q, done_q, fault_q;
    logic                soda_req_d, dime_req_d, nickel_req_d, busy_d, done_d, fault_d;

    logic                coin_ack;
    logic [CHANGE_W-1:0] coin_units;
    logic                tmr_clr, tmr_en, tmr_expire;

    assign coin_ack   = (coin_q == COIN_DIME) ? i_dime_ack : i_nickel_ack;
    assign coin_units = (coin_q == COIN_DIME) ? CHANGE_W'(DIME_UNITS) : CHANGE_W'(NICKEL_UNITS);

    assign tmr_en  = (state_q == SODA && !i_soda_ack) || (state_q == COIN_REQ && !coin_ack);
    assign tmr_clr = (state_d != state_q) && (state_d == SODA || state_d == COIN_REQ);

    hs_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMR_W       (TMR_W)
    ) u_hs_timer (
        .clk_i    (i_clk),
        .rst_i    (reset),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        coin_d      = coin_q;
        remaining_d = remaining_q;
        unique case (state_q)
            IDLE: begin
                if (i_vend) begin
                    remaining_d = i_change;
                    state_d     = SODA;
                end
            end
            SODA: begin
                if (i_soda_ack) begin
                    state_d = (remaining_q != '0) ? COIN_GAP : DONE;
                end else if (tmr_expire) begin
                    state_d = FAULT;
                end
            end
            COIN_GAP: begin
                // A dime is only chosen when at least two nickels are owed.
                coin_d  = (remaining_q >= CHANGE_W'(DIME_UNITS) && !i_dime_empty) ?
                          COIN_DIME : COIN_NICKEL;
                state_d = COIN_REQ;
            end
            COIN_REQ: begin
                if (coin_ack) begin
                    remaining_d = remaining_q - coin_units;
                    state_d     = (remaining_d != '0) ? COIN_GAP : DONE;
                end else if (tmr_expire) begin
                    state_d = FAULT;
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of the next-state decode.
        soda_req_d   = (state_d == SODA);
        dime_req_d   = (state_d == COIN_REQ) && (coin_d == COIN_DIME);
        nickel_req_d = (state_d == COIN_REQ) && (coin_d == COIN_NICKEL);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        fault_d      = (state_d == FAULT);
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            coin_q       <= COIN_NICKEL;
            remaining_q  <= '0;
            soda_req_q   <= 1'b0;
            dime_req_q   <= 1'b0;
            nickel_req_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            coin_q       <= coin_d;
            remaining_q  <= remaining_d;
            soda_req_q   <= soda_req_d;
            dime_req_q   <= dime_req_d;
            nickel_req_q <= nickel_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
        end
    end

    assign o_soda_req   = soda_req_q;
    assign o_dime_req   = dime_req_q;
    assign o_nickel_req = nickel_req_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_fault      = fault_q;

`ifdef CHANGE_LOG_EN
    logic [7:0] paid_q, paid_d;
    logic [8:0] paid_sum;

    always_comb begin
        paid_sum = {1'b0, paid_q} + 9'(coin_q == COIN_DIME ? DIME_UNITS : NICKEL_UNITS);
        paid_d   = paid_q;
        if (state_q == COIN_REQ && coin_ack) begin
            paid_d = paid_sum[8] ? 8'hFF : paid_sum[7:0];
        end
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            paid_q <= 8'd0;
        end else begin
            paid_q <= paid_d;
        end
    end

    assign o_nickels_paid = paid_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser; acts as the vending controller and the
// three actuators. Define CHANGE_LOG_EN to also exercise o_nickels_paid.
module tb_change_dispenser;

    localparam int KDime   = 1;
    localparam int KNickel = 2;

    logic       i_clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_vend = 1'b0;
    logic [2:0] i_change = 3'd0;
    logic       i_dime_empty = 1'b0;
    logic       i_soda_ack = 1'b0;
    logic       i_dime_ack = 1'b0;
    logic       i_nickel_ack = 1'b0;
    logic       o_soda_req, o_dime_req, o_nickel_req, o_busy, o_done, o_fault;
`ifdef CHANGE_LOG_EN
    logic [7:0] o_nickels_paid;
`endif

    int checks = 0;
    int errors = 0;

    int   dime_rises = 0, nickel_rises = 0, done_cnt = 0, gap_err = 0;
    logic prev_soda = 1'b0, prev_dime = 1'b0, prev_nickel = 1'b0;

    change_dispenser #(
        .CHANGE_W    (3),
        .TIMEOUT_CYC (16),
        .TMR_W       (5)
    ) dut (
        .i_clk        (i_clk),
        .reset        (reset),
        .i_vend       (i_vend),
        .i_change     (i_change),
        .i_dime_empty (i_dime_empty),
        .o_soda_req   (o_soda_req),
        .i_soda_ack   (i_soda_ack),
        .o_dime_req   (o_dime_req),
        .i_dime_ack   (i_dime_ack),
        .o_nickel_req (o_nickel_req),
        .i_nickel_ack (i_nickel_ack),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_fault      (o_fault)
`ifdef CHANGE_LOG_EN
        ,
        .o_nickels_paid (o_nickels_paid)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Request-rise and done-pulse monitor; a rise right after any request was
    // high means the mandatory all-low gap cycle was skipped.
    always @(negedge i_clk) begin
        if (o_dime_req && !prev_dime) dime_rises <= dime_rises + 1;
        if (o_nickel_req && !prev_nickel) nickel_rises <= nickel_rises + 1;
        if (((o_soda_req && !prev_soda) || (o_dime_req && !prev_dime) ||
             (o_nickel_req && !prev_nickel)) && (prev_soda || prev_dime || prev_nickel))
            gap_err <= gap_err + 1;
        if (o_done) done_cnt <= done_cnt + 1;
        prev_soda   <= o_soda_req;
        prev_dime   <= o_dime_req;
        prev_nickel <= o_nickel_req;
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic vend(input logic [2:0] change);
        i_vend   = 1'b1;
        i_change = change;
        step();
        i_vend   = 1'b0;
        i_change = 3'd0;
    endtask

    task automatic serve_soda(input int delay, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (o_soda_req) ok = 1'b1;
            else step();
        end
        if (ok) begin
            repeat (delay) step();
            i_soda_ack = 1'b1;
            step();
            i_soda_ack = 1'b0;
        end
    endtask

    task automatic serve_coin(input int delay, output int kind, output bit ok);
        kind = 0;
        ok   = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (o_dime_req) begin
                kind = KDime;
                ok   = 1'b1;
            end else if (o_nickel_req) begin
                kind = KNickel;
                ok   = 1'b1;
            end else begin
                step();
            end
        end
        if (ok) begin
            repeat (delay) step();
            if (kind == KDime) i_dime_ack = 1'b1;
            else i_nickel_ack = 1'b1;
            step();
            i_dime_ack   = 1'b0;
            i_nickel_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if ({o_soda_req, o_dime_req, o_nickel_req, o_busy, o_done, o_fault} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {o_soda_req, o_dime_req, o_nickel_req, o_busy, o_done, o_fault});
        end
        reset = 1'b0;
        step();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", o_busy);
        end
    endtask

    task automatic test_zero_change();
        int d0, n0, c0;
        d0 = dime_rises; n0 = nickel_rises; c0 = done_cnt;
        vend(3'd0);
        checks++;
        if ({o_soda_req, o_busy} !== 2'b11) begin
            errors++;
            $display("FAIL zero_soda_busy: got %b expected 11", {o_soda_req, o_busy});
        end
        repeat (2) step();
        i_soda_ack = 1'b1;
        step();
        i_soda_ack = 1'b0;
        checks++;
        if ({o_soda_req, o_done, o_busy} !== 3'b011) begin
            errors++;
            $display("FAIL zero_done: got %b expected 011", {o_soda_req, o_done, o_busy});
        end
        step();
        checks++;
        if ({o_done, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL zero_after_done: got %b expected 00", {o_done, o_busy});
        end
        step();
        checks++;
        if (dime_rises - d0 + nickel_rises - n0 !== 0 || done_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL zero_counts: got coins %0d dones %0d expected 0 1",
                     dime_rises - d0 + nickel_rises - n0, done_cnt - c0);
        end
    endtask

    task automatic test_change3();
        int  d0, n0, c0, g0, k1, k2;
        bit  ok1, ok2, ok3;
        d0 = dime_rises; n0 = nickel_rises; c0 = done_cnt; g0 = gap_err;
        i_dime_empty = 1'b0;
        vend(3'd3);
        serve_soda(2, ok1);
        checks++;
        if (!ok1 || {o_soda_req, o_dime_req, o_nickel_req, o_busy} !== 4'b0001) begin
            errors++;
            $display("FAIL c3_gap_after_soda: got ok=%0d %b expected ok=1 0001", ok1,
                     {o_soda_req, o_dime_req, o_nickel_req, o_busy});
        end
        serve_coin(2, k1, ok2);
        serve_coin(2, k2, ok3);
        checks++;
        if (!ok2 || !ok3 || k1 !== KDime || k2 !== KNickel) begin
            errors++;
            $display("FAIL c3_coin_order: got %0d,%0d expected %0d,%0d", k1, k2, KDime, KNickel);
        end
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL c3_done: got %b expected 1", o_done);
        end
        repeat (2) step();
        checks++;
        if (dime_rises - d0 !== 1 || nickel_rises - n0 !== 1 || done_cnt - c0 !== 1 ||
            gap_err - g0 !== 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL c3_counts: got d=%0d n=%0d done=%0d gaperr=%0d busy=%b expected 1 1 1 0 0",
                     dime_rises - d0, nickel_rises - n0, done_cnt - c0, gap_err - g0, o_busy);
        end
    endtask

    task automatic test_empty_dime();
        int d0, n0, k, nick;
        bit ok, all_ok;
        d0 = dime_rises; n0 = nickel_rises; nick = 0; all_ok = 1'b1;
        i_dime_empty = 1'b1;
        vend(3'd4);
        serve_soda(1, ok);
        all_ok = ok;
        for (int i = 0; i < 4; i++) begin
            serve_coin(1, k, ok);
            all_ok = all_ok && ok;
            if (k == KNickel) nick++;
        end
        checks++;
        if (!all_ok || nick !== 4 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL empty_nickels: got ok=%0d nickels=%0d done=%b expected 1 4 1",
                     all_ok, nick, o_done);
        end
        step();
        step();
        checks++;
        if (dime_rises - d0 !== 0 || nickel_rises - n0 !== 4) begin
            errors++;
            $display("FAIL empty_counts: got d=%0d n=%0d expected 0 4",
                     dime_rises - d0, nickel_rises - n0);
        end
        i_dime_empty = 1'b0;
    endtask

    task automatic test_timeout();
        int hi;
        bit ok;
        vend(3'd1);
        // Ack lands on the last permitted cycle: it must win over expiry.
        serve_soda(15, ok);
        checks++;
        if (!ok || o_fault !== 1'b0 || o_soda_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_at_expiry: got ok=%0d fault=%b soda=%b expected 1 0 0",
                     ok, o_fault, o_soda_req);
        end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (o_nickel_req) ok = 1'b1;
            else step();
        end
        hi = 0;
        for (int i = 0; i < 40 && o_nickel_req; i++) begin
            hi++;
            step();
        end
        checks++;
        if (!ok || hi !== 16) begin
            errors++;
            $display("FAIL timeout_len: got ok=%0d cycles=%0d expected 1 16", ok, hi);
        end
        checks++;
        if ({o_nickel_req, o_fault, o_busy, o_done} !== 4'b0110) begin
            errors++;
            $display("FAIL timeout_fault: got %b expected 0110",
                     {o_nickel_req, o_fault, o_busy, o_done});
        end
        vend(3'd2);
        repeat (5) step();
        checks++;
        if ({o_soda_req, o_dime_req, o_nickel_req, o_fault, o_busy, o_done} !== 6'b000110) begin
            errors++;
            $display("FAIL fault_sticky: got %b expected 000110",
                     {o_soda_req, o_dime_req, o_nickel_req, o_fault, o_busy, o_done});
        end
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
        checks++;
        if ({o_fault, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL fault_cleared: got %b expected 00", {o_fault, o_busy});
        end
    endtask

    task automatic test_busy_vend_and_reset();
        int k;
        bit ok1, ok2;
        i_dime_empty = 1'b0;
        vend(3'd1);
        vend(3'd4);
        serve_soda(0, ok1);
        serve_coin(0, k, ok2);
        checks++;
        if (!ok1 || !ok2 || k !== KNickel || o_done !== 1'b1) begin
            errors++;
            $display("FAIL busy_vend_ignored: got ok=%0d%0d coin=%0d done=%b expected 11 %0d 1",
                     ok1, ok2, k, o_done, KNickel);
        end
        repeat (2) step();
        vend(3'd2);
        serve_soda(0, ok1);
        ok2 = 1'b0;
        for (int i = 0; i < 40 && !ok2; i++) begin
            if (o_dime_req) ok2 = 1'b1;
            else step();
        end
        checks++;
        if (!ok1 || !ok2) begin
            errors++;
            $display("FAIL mid_dime_req: got ok=%0d%0d expected 11", ok1, ok2);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({o_soda_req, o_dime_req, o_nickel_req, o_busy, o_done, o_fault} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 000000",
                     {o_soda_req, o_dime_req, o_nickel_req, o_busy, o_done, o_fault});
        end
        #2;
        reset = 1'b0;
        step();
        vend(3'd0);
        checks++;
        if ({o_soda_req, o_busy} !== 2'b11) begin
            errors++;
            $display("FAIL post_reset_vend: got %b expected 11", {o_soda_req, o_busy});
        end
        serve_soda(0, ok1);
        checks++;
        if (!ok1 || o_done !== 1'b1 || o_dime_req !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_done: got ok=%0d done=%b dime=%b expected 1 1 0",
                     ok1, o_done, o_dime_req);
        end
        step();
    endtask

`ifdef CHANGE_LOG_EN
    task automatic test_change_log();
        int k;
        bit ok;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
        checks++;
        if (o_nickels_paid !== 8'd0) begin
            errors++;
            $display("FAIL log_reset: got %0d expected 0", o_nickels_paid);
        end
        i_dime_empty = 1'b0;
        vend(3'd3);
        serve_soda(0, ok);
        for (int i = 0; i < 8 && !o_done; i++) serve_coin(0, k, ok);
        step();
        vend(3'd4);
        serve_soda(0, ok);
        for (int i = 0; i < 8 && !o_done; i++) serve_coin(0, k, ok);
        repeat (2) step();
        checks++;
        if (o_nickels_paid !== 8'd7) begin
            errors++;
            $display("FAIL log_total: got %0d expected 7", o_nickels_paid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_change();
        test_change3();
        test_empty_dime();
        test_timeout();
        test_busy_vend_and_reset();
`ifdef CHANGE_LOG_EN
        test_change_log();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
